dl11_uart_rx: RTL and testbench
===============================

Name: dl11_uart_rx

Overview:
- Oversampling asynchronous serial receiver for the DL11 console path.
- Sits directly upstream of the console register block: it deserialises rs232_rx into an 8-bit holding register.
- Presents the rx_data / rx_empty / uld_rx_data unload handshake that the console register block's tti state machine consumes.
- Adds start-bit glitch rejection, framing-error and overrun flags, and break (line-held-low) handling.

Parameters:
OVERSAMPLE, 16, rxclk ticks per bit time; must be even and >= 4
DATA_BITS, 8, data bits per character, LSB first, no parity
SYNC_STAGES, 2, flip-flops in the rx_in synchroniser

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
rxclk  input  1  single-clk-cycle enable pulse at OVERSAMPLE x baud (from the baud rate generator)
rx_enable  input  1  0 forces the receive FSM to IDLE; holding register and flags are retained
rx_in  input  1  asynchronous serial line, idle high
uld_rx_data  input  1  unload request; level-sensitive, consumed every clk it is high
rx_data  output  DATA_BITS  holding register, valid while rx_empty=0
rx_empty  output  1  1 = no unread character
rx_frame_err  output  1  stop bit of the held character was 0
rx_overrun  output  1  a character arrived while the holding register was full (sticky)

Behaviour:
- Reset values: rx_data=0, rx_empty=1, rx_frame_err=0, rx_overrun=0, FSM=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: rx_in passes through SYNC_STAGES flops on clk. All line sampling uses the synchronised value rxs.
- The FSM and tick counter advance only on clk edges where rxclk=1. Exceptions, which act on any clk edge regardless of rxclk: reset, rx_enable=0, and the holding-register logic.
- FSM states:
  - IDLE: on a tick with rxs=0 -> START, cnt=0.
  - START: cnt increments per tick. At cnt=OVERSAMPLE/2-1: if rxs=0 -> DATA with cnt=0, bit=0; if rxs=1 -> IDLE (glitch, nothing loaded).
  - DATA: at cnt=OVERSAMPLE-1, sample rxs into shift[bit] (LSB first), cnt=0, bit++. After DATA_BITS samples -> STOP.
  - STOP: at cnt=OVERSAMPLE-1, sample rxs, then load the holding register. rxs=1 -> IDLE; rxs=0 -> BREAK.
  - BREAK: wait for a tick with rxs=1 -> IDLE. No characters are started while in BREAK.
- Load: on the clk after the stop sample tick:
  - rx_data=shift, rx_empty=0, rx_frame_err=~stop_sample.
  - If rx_empty was already 0 and uld_rx_data=0 that cycle: set rx_overrun=1. The new character overwrites the old one.
- Unload: clk with uld_rx_data=1 and no load that cycle sets rx_empty=1 and clears rx_frame_err and rx_overrun. rx_data is unchanged.
- Simultaneous load and unload on the same clk: load wins, leaving rx_empty=0 with the new data and frame_err from the new character. Overrun is cleared, not set.
- uld_rx_data held high continuously: each arriving character appears for exactly one clk with rx_empty=0, then is unloaded.
- rx_enable=0 mid-character: FSM -> IDLE on that clk and the partial character is discarded. When re-enabled, reception resumes at the next falling edge.
- Reset mid-character: all state returns to reset values on that clk.
- Latency: rx_empty falls exactly 1 clk after the rxclk tick that samples the stop bit, and SYNC_STAGES+1 clks later than the line edge would imply at most.
- Counter widths: cnt is clog2(OVERSAMPLE) bits; bit is clog2(DATA_BITS+1) bits. Neither counter wraps within a state.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3 bits) and the default OVERSAMPLE/DATA_BITS constants, shared with the baud rate generator and the transmit side.
- One natural sub-module: dl11_sync, the SYNC_STAGES-deep synchroniser with reset value 1.
- Everything else stays in one module.

Test Plan:
1. Bench drives rxclk every 4th clk (64 clk/bit) and sends frame 0x55 with a good stop bit -> rx_data=8'h55, rx_empty=0, rx_frame_err=0 one clk after the stop tick. Pulse uld_rx_data -> rx_empty=1 next clk.
2. Hold rx_in low for 3 ticks only, then high -> FSM returns to IDLE, rx_empty stays 1, nothing loaded.
3. Send 0xA3 with the stop bit driven 0, then hold the line low for 2 bit times -> rx_data=8'hA3, rx_frame_err=1. No second character while low. After the line goes high, send 0x41 -> accepted normally.
4. Send 0x12 then 0x34 with no unload -> rx_data=8'h34, rx_overrun=1, rx_empty=0. Unload -> rx_empty=1, rx_overrun=0.
5. Assert uld_rx_data on the exact clk the stop load occurs (second character 0x7E pending) -> rx_empty=0, rx_data=8'h7E, rx_overrun=0.
6. Deassert rx_enable during bit 4 of 0xFF, re-enable, then send 0x0D -> only 0x0D is loaded. Assert reset mid-character -> all outputs return to reset values next clk.

Source files
------------

// File: rtl/dl11_uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dl11_uart_rx_pkg
// Description : Shared constants and receive-FSM encoding for the DL11 serial path.
// Revision    : 1.0 - initial release
// ============================================================================
package dl11_uart_rx_pkg;

    localparam int c_default_oversample  = 16;
    localparam int c_default_data_bits   = 8;
    localparam int c_default_sync_stages = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/dl11_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : dl11_uart_rx_if
// Description : Holding-register unload handshake between receiver and console block.
// Revision    : 1.0 - initial release
// ============================================================================
interface dl11_uart_rx_if
    import dl11_uart_rx_pkg::*;
#(
    parameter int DATA_BITS = c_default_data_bits
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 uld_rx_data;

    modport master (
        output rx_data,
        output rx_empty,
        output rx_frame_err,
        output rx_overrun,
        input  uld_rx_data
    );

    modport slave (
        input  rx_data,
        input  rx_empty,
        input  rx_frame_err,
        input  rx_overrun,
        output uld_rx_data
    );
endinterface
`default_nettype wire

// File: rtl/dl11_sync.sv
`default_nettype none
// ============================================================================
// Module      : dl11_sync
// Description : Multi-flop synchroniser for the idle-high serial line; resets to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module dl11_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_d,
    output logic      o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/dl11_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : dl11_uart_rx
// Description : Oversampling DL11 serial receiver with holding register and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dl11_uart_rx
    import dl11_uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE  = c_default_oversample,
    parameter int DATA_BITS   = c_default_data_bits,
    parameter int SYNC_STAGES = c_default_sync_stages
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      rxclk,
    input  wire logic      rx_enable,
    input  wire logic      rx_in,
    dl11_uart_rx_if.master rx_bus
);
    localparam int c_cnt_w = $clog2(OVERSAMPLE);
    localparam int c_bit_w = $clog2(DATA_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);

    logic                 w_rxs;
    rx_state_t            r_state, w_state_next;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
    logic [c_bit_w-1:0]   r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_load, w_load_next;
    logic                 r_stop, w_stop_next;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_empty;
    logic                 r_frame_err;
    logic                 r_overrun;

    dl11_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_in),
        .o_q   (w_rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_load  <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_load  <= w_load_next;
            r_stop  <= w_stop_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_load_next  = 1'b0;
        w_stop_next  = r_stop;

        if (!rx_enable) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_bit_next   = '0;
        end else if (rxclk) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        w_state_next = ST_START;
                        w_cnt_next   = '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit recheck rejects line glitches shorter than half a bit.
                    if (r_cnt == c_cnt_half) begin
                        w_cnt_next   = '0;
                        w_bit_next   = '0;
                        w_state_next = w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_cnt_full) begin
                        w_cnt_next   = '0;
                        w_shift_next = {w_rxs, r_shift[DATA_BITS-1:1]};
                        w_bit_next   = r_bit + 1'b1;
                        if (r_bit == c_bit_last) begin
                            w_state_next = ST_STOP;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_cnt_full) begin
                        w_cnt_next   = '0;
                        w_stop_next  = w_rxs;
                        w_load_next  = 1'b1;
                        w_state_next = w_rxs ? ST_IDLE : ST_BREAK;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rxs) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // A load in the same clk as an unload takes priority and clears overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= '0;
            r_empty     <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_load) begin
            r_data      <= r_shift;
            r_empty     <= 1'b0;
            r_frame_err <= ~r_stop;
            if (rx_bus.uld_rx_data) begin
                r_overrun <= 1'b0;
            end else if (!r_empty) begin
                r_overrun <= 1'b1;
            end
        end else if (rx_bus.uld_rx_data) begin
            r_empty     <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end
    end

    assign rx_bus.rx_data      = r_data;
    assign rx_bus.rx_empty     = r_empty;
    assign rx_bus.rx_frame_err = r_frame_err;
    assign rx_bus.rx_overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_dl11_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl11_uart_rx
// Description : Directed self-checking bench for dl11_uart_rx at 64 clk per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl11_uart_rx;
    logic clk = 1'b0;
    logic reset;
    logic rxclk;
    logic rx_enable;
    logic rx_in;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   phase   = 0;
    logic e613, e614, e615;

    dl11_uart_rx_if #(.DATA_BITS(8)) bus ();

    dl11_uart_rx #(
        .OVERSAMPLE  (16),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxclk     (rxclk),
        .rx_enable (rx_enable),
        .rx_in     (rx_in),
        .rx_bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       unload;
        logic       chk_lat;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [7];

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One clk; rxclk is a tick on every 4th edge, driven just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        rxclk = (phase == 3);
        phase = (phase + 1) % 4;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_values(input string tag);
        check8({tag, "_data"},  bus.rx_data,      8'h00);
        check1({tag, "_empty"}, bus.rx_empty,     1'b1);
        check1({tag, "_fe"},    bus.rx_frame_err, 1'b0);
        check1({tag, "_ovr"},   bus.rx_overrun,   1'b0);
    endtask

    // Frame starts in the slot whose next edge is a tick, so the stop bit is
    // sampled at slot 613 and the holding register loads at edge 614.
    // uld_at: -1 none, -2 held high all frame, else the slot it pulses in.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int uld_at,
                              input int dis_at, input int rst_at,
                              output logic o613, output logic o614, output logic o615);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        o613 = 1'bx;
        o614 = 1'bx;
        o615 = 1'bx;
        step();
        while (phase != 0) step();
        for (int n = 0; n < 640; n++) begin
            if (n % 64 == 0) rx_in = bits[n / 64];
            bus.uld_rx_data = (uld_at == -2) || (n == uld_at);
            rx_enable = !(dis_at >= 0 && n >= dis_at && n < dis_at + 8);
            reset = (n == rst_at);
            if (rst_at >= 0 && n == rst_at + 1) check_reset_values("mid_reset");
            if (n == 613) o613 = bus.rx_empty;
            if (n == 614) o614 = bus.rx_empty;
            if (n == 615) o615 = bus.rx_empty;
            step();
        end
        bus.uld_rx_data = 1'b0;
        rx_enable = 1'b1;
        reset = 1'b0;
    endtask

    task automatic unload(input string tag, input logic [7:0] exp_data);
        bus.uld_rx_data = 1'b1;
        step();
        bus.uld_rx_data = 1'b0;
        check1({tag, "_uld_empty"}, bus.rx_empty,     1'b1);
        check1({tag, "_uld_fe"},    bus.rx_frame_err, 1'b0);
        check1({tag, "_uld_ovr"},   bus.rx_overrun,   1'b0);
        check8({tag, "_uld_data"},  bus.rx_data,      exp_data);
    endtask

    task automatic check_held(input string tag, input logic [7:0] d, input logic fe, input logic ovr);
        check8({tag, "_data"},  bus.rx_data,      d);
        check1({tag, "_empty"}, bus.rx_empty,     1'b0);
        check1({tag, "_fe"},    bus.rx_frame_err, fe);
        check1({tag, "_ovr"},   bus.rx_overrun,   ovr);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
        vecs[6] = '{8'h34, 1'b1, 1'b1, 1'b0, 8'h34, 1'b0, 1'b1};

        reset = 1'b1;
        rxclk = 1'b0;
        rx_enable = 1'b1;
        rx_in = 1'b1;
        bus.uld_rx_data = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset = 1'b0;
        idle(8);

        // Normal frames, overrun pair 0x12 / 0x34
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, -1, -1, -1, e613, e614, e615);
            idle(16);
            if (vecs[i].chk_lat) begin
                check1("lat_before_load", e613, 1'b1);
                check1("lat_at_load",     e614, 1'b0);
            end
            check_held("vec", vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_ovr);
            if (vecs[i].unload) unload("vec", vecs[i].exp_data);
        end

        // Start glitch of 3 ticks
        step();
        while (phase != 0) step();
        rx_in = 1'b0;
        idle(12);
        rx_in = 1'b1;
        idle(700);
        check1("glitch_empty", bus.rx_empty, 1'b1);

        // Framing error followed by a held-low break
        send_frame(8'hA3, 1'b0, -1, -1, -1, e613, e614, e615);
        check1("brk_lat", e614, 1'b0);
        check_held("brk_load", 8'hA3, 1'b1, 1'b0);
        idle(128);
        rx_in = 1'b1;
        idle(700);
        check_held("brk_after", 8'hA3, 1'b1, 1'b0);
        unload("brk", 8'hA3);
        send_frame(8'h41, 1'b1, -1, -1, -1, e613, e614, e615);
        idle(16);
        check1("post_brk_lat", e614, 1'b0);
        check_held("post_brk", 8'h41, 1'b0, 1'b0);
        unload("post_brk", 8'h41);

        // Unload on the exact load clk while full
        send_frame(8'h11, 1'b1, -1, -1, -1, e613, e614, e615);
        idle(16);
        send_frame(8'h7E, 1'b1, 613, -1, -1, e613, e614, e615);
        idle(16);
        check1("sim_pre", e613, 1'b0);
        check1("sim_at",  e614, 1'b0);
        check_held("sim", 8'h7E, 1'b0, 1'b0);
        unload("sim", 8'h7E);

        // Unload held high: character visible for exactly one clk
        send_frame(8'h3C, 1'b1, -2, -1, -1, e613, e614, e615);
        idle(4);
        check1("hold_pre",  e613, 1'b1);
        check1("hold_at",   e614, 1'b0);
        check1("hold_next", e615, 1'b1);
        check8("hold_data", bus.rx_data, 8'h3C);

        // Disable during bit 4 of 0xFF discards it; 0x0D then loads
        send_frame(8'hFF, 1'b1, -1, 340, -1, e613, e614, e615);
        idle(16);
        check1("dis_empty", bus.rx_empty, 1'b1);
        send_frame(8'h0D, 1'b1, -1, -1, -1, e613, e614, e615);
        idle(16);
        check1("dis_next_lat", e614, 1'b0);
        check_held("dis_next", 8'h0D, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, -1, -1, -1, e613, e614, e615);
        idle(16);
        check_held("pre_rst", 8'h5A, 1'b0, 1'b1);

        // Reset mid-character, checked inside send_frame
        send_frame(8'hFF, 1'b1, -1, -1, 300, e613, e614, e615);
        idle(32);
        check_reset_values("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
